// File: rtl/chain_split_min_pipe_if.sv
// ============================================================================
// chain_split_min_pipe_if: candidate stream and cell result bus for the split-point evaluator
// Revision: 1.0
// ============================================================================
`default_nettype none

interface chain_split_min_pipe_if #(
  parameter int DIM_W  = 8,
  parameter int COST_W = 32,
  parameter int K_W    = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic [DIM_W-1:0]  in_pi;
  logic [DIM_W-1:0]  in_pk;
  logic [DIM_W-1:0]  in_pj;
  logic [COST_W-1:0] in_mki;
  logic [COST_W-1:0] in_mkj1;
  logic [K_W-1:0]    in_k;
  logic              out_valid;
  logic              out_ready;
  logic [COST_W-1:0] out_min;
  logic [K_W-1:0]    out_k;
  logic              out_sat;
  logic [K_W-1:0]    out_count;

  modport master (
    output in_valid, in_first, in_last, in_pi, in_pk, in_pj, in_mki, in_mkj1, in_k, out_ready,
    input  in_ready, out_valid, out_min, out_k, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_first, in_last, in_pi, in_pk, in_pj, in_mki, in_mkj1, in_k, out_ready,
    output in_ready, out_valid, out_min, out_k, out_sat, out_count
  );
endinterface

`default_nettype wire

// File: rtl/chain_split_min_pipe.sv
// ============================================================================
// chain_split_min_pipe: pipelined min/argmin over matrix-chain split candidates, one result per cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module chain_split_min_pipe #(
  parameter int DIM_W  = 8,
  parameter int COST_W = 32,
  parameter int K_W    = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  chain_split_min_pipe_if.slave bus
);
  localparam int PROD_W = 3 * DIM_W;
  localparam int SUM_W  = COST_W + PROD_W + 2;
  localparam logic [SUM_W-1:0] SAT_LIM = {{(PROD_W + 2){1'b0}}, {COST_W{1'b1}}};

  logic              en;

  logic              s1_vld_q, s1_first_q, s1_last_q;
  logic [PROD_W-1:0] s1_prod_q;
  logic [COST_W-1:0] s1_mki_q, s1_mkj1_q;
  logic [K_W-1:0]    s1_k_q;

  logic              s2_vld_q, s2_first_q, s2_last_q;
  logic [SUM_W-1:0]  s2_sum_q;
  logic [K_W-1:0]    s2_k_q;

  logic              s3_vld_q, s3_first_q, s3_last_q, s3_sat_q;
  logic [COST_W-1:0] s3_cost_q;
  logic [K_W-1:0]    s3_k_q;

  logic              open_q, open_d;
  logic [COST_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]    acc_k_q, acc_k_d;
  logic              acc_sat_q, acc_sat_d;
  logic [K_W-1:0]    cnt_q, cnt_d;

  logic              out_valid_q, out_sat_q;
  logic [COST_W-1:0] out_min_q;
  logic [K_W-1:0]    out_k_q, out_count_q;

  logic [PROD_W-1:0] prod_d;
  logic [SUM_W-1:0]  sum_d;
  logic              sat_d;
  logic [COST_W-1:0] cost_d;
  logic              start_w, take_w;

  // The whole pipe freezes only while a finished result is waiting to be taken.
  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en;

  assign prod_d = PROD_W'(bus.in_pi) * PROD_W'(bus.in_pk) * PROD_W'(bus.in_pj);
  assign sum_d  = SUM_W'(s1_mki_q) + SUM_W'(s1_mkj1_q) + SUM_W'(s1_prod_q);
  assign sat_d  = (s2_sum_q >= SAT_LIM);
  assign cost_d = sat_d ? {COST_W{1'b1}} : s2_sum_q[COST_W-1:0];

  // A beat with no open cell starts one even without in_first.
  assign start_w = s3_first_q || !open_q;
  assign take_w  = start_w || (s3_cost_q < acc_q);

  always_comb begin
    acc_d     = take_w ? s3_cost_q : acc_q;
    acc_k_d   = take_w ? s3_k_q    : acc_k_q;
    acc_sat_d = take_w ? s3_sat_q  : acc_sat_q;
    cnt_d     = start_w ? K_W'(1) : cnt_q + K_W'(1);
    open_d    = !s3_last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      s1_mki_q    <= '0;
      s1_mkj1_q   <= '0;
      s1_k_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_k_q      <= '0;
      s3_vld_q    <= 1'b0;
      s3_first_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_sat_q    <= 1'b0;
      s3_cost_q   <= '0;
      s3_k_q      <= '0;
    end else if (en) begin
      s1_vld_q    <= bus.in_valid;
      s1_first_q  <= bus.in_first;
      s1_last_q   <= bus.in_last;
      s1_prod_q   <= prod_d;
      s1_mki_q    <= bus.in_mki;
      s1_mkj1_q   <= bus.in_mkj1;
      s1_k_q      <= bus.in_k;
      s2_vld_q    <= s1_vld_q;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;
      s2_sum_q    <= sum_d;
      s2_k_q      <= s1_k_q;
      s3_vld_q    <= s2_vld_q;
      s3_first_q  <= s2_first_q;
      s3_last_q   <= s2_last_q;
      s3_sat_q    <= sat_d;
      s3_cost_q   <= cost_d;
      s3_k_q      <= s2_k_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_q      <= 1'b0;
      acc_q       <= {COST_W{1'b1}};
      acc_k_q     <= '0;
      acc_sat_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= {COST_W{1'b1}};
      out_k_q     <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else if (en) begin
      if (s3_vld_q) begin
        open_q    <= open_d;
        acc_q     <= acc_d;
        acc_k_q   <= acc_k_d;
        acc_sat_q <= acc_sat_d;
        cnt_q     <= cnt_d;
      end
      // en here means any pending result was just taken, so valid follows the new last.
      out_valid_q <= s3_vld_q && s3_last_q;
      if (s3_vld_q && s3_last_q) begin
        out_min_q   <= acc_d;
        out_k_q     <= acc_k_d;
        out_sat_q   <= acc_sat_d;
        out_count_q <= cnt_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_k     = out_k_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_count = out_count_q;
endmodule

`default_nettype wire

// File: tb/tb_chain_split_min_pipe.sv
// ============================================================================
// tb_chain_split_min_pipe: directed vectors for the split-point evaluator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chain_split_min_pipe;
  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  typedef struct packed {
    logic [31:0] mn;
    logic [7:0]  k;
    logic        sat;
    logic [7:0]  cnt;
  } res_t;

  res_t rq[$];

  chain_split_min_pipe_if bus_if ();

  chain_split_min_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  always @(posedge clk) begin
    if (rst && bus_if.out_valid && bus_if.out_ready)
      rq.push_back({bus_if.out_min, bus_if.out_k, bus_if.out_sat, bus_if.out_count});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic f, input logic l, input logic [7:0] pi, input logic [7:0] pk,
                      input logic [7:0] pj, input logic [31:0] mki, input logic [31:0] mkj1,
                      input logic [7:0] k);
    bit done = 1'b0;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_first = f;
    bus_if.in_last  = l;
    bus_if.in_pi    = pi;
    bus_if.in_pk    = pk;
    bus_if.in_pj    = pj;
    bus_if.in_mki   = mki;
    bus_if.in_mkj1  = mkj1;
    bus_if.in_k     = k;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk);
      if (bus_if.in_ready) done = 1'b1;
    end
    if (!done) check("send_timeout", 64'(bus_if.in_ready), 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_first = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] mn, input logic [7:0] k,
                             input logic sat, input logic [7:0] cnt);
    res_t r;
    for (int n = 0; n < 40 && rq.size() == 0; n++) @(negedge clk);
    if (rq.size() == 0) begin
      check({tag, "_timeout"}, 64'(rq.size()), 64'd1);
    end else begin
      r = rq.pop_front();
      check({tag, "_min"}, 64'(r.mn), 64'(mn));
      check({tag, "_k"},   64'(r.k),  64'(k));
      check({tag, "_sat"}, 64'(r.sat), 64'(sat));
      check({tag, "_cnt"}, 64'(r.cnt), 64'(cnt));
    end
  endtask

  initial begin
    rst               = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_first   = 1'b0;
    bus_if.in_last    = 1'b0;
    bus_if.in_pi      = '0;
    bus_if.in_pk      = '0;
    bus_if.in_pj      = '0;
    bus_if.in_mki     = '0;
    bus_if.in_mkj1    = '0;
    bus_if.in_k       = '0;
    bus_if.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_min",   64'(bus_if.out_min),   64'hFFFF_FFFF);
    check("rst_k",     64'(bus_if.out_k),     64'd0);
    check("rst_sat",   64'(bus_if.out_sat),   64'd0);
    check("rst_cnt",   64'(bus_if.out_count), 64'd0);
    check("rst_ready", 64'(bus_if.in_ready),  64'd1);
    rst = 1'b1;

    // p=(10,30,5,60): k=1 -> 18000+9000=27000, k=2 -> 3000+1500=4500
    send(1'b1, 1'b0, 8'd10, 8'd30, 8'd60, 32'd0,    32'd9000, 8'd1);
    send(1'b0, 1'b1, 8'd10, 8'd5,  8'd60, 32'd1500, 32'd0,    8'd2);
    idle();
    repeat (2) @(posedge clk);
    #1 check("t1_lat_early", 64'(bus_if.out_valid), 64'd0);
    @(posedge clk);
    #1 check("t1_lat_valid", 64'(bus_if.out_valid), 64'd1);
    check("t1_direct_min", 64'(bus_if.out_min), 64'd4500);
    wait_result("t1", 32'd4500, 8'd2, 1'b0, 8'd2);

    send(1'b1, 1'b0, 8'd1, 8'd1, 8'd0, 32'd700, 32'd0,   8'd3);
    send(1'b0, 1'b1, 8'd2, 8'd0, 8'd9, 32'd300, 32'd400, 8'd4);
    idle();
    wait_result("t2_tie", 32'd700, 8'd3, 1'b0, 8'd2);

    send(1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 32'hFFFF_FFF0, 32'd0, 8'd9);
    idle();
    wait_result("t3_sat", 32'hFFFF_FFFF, 8'd9, 1'b1, 8'd1);

    @(negedge clk);
    bus_if.out_ready = 1'b0;
    send(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 32'd5, 32'd0, 8'd11);
    send(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 32'd9, 32'd0, 8'd12);
    send(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 32'd2, 32'd0, 8'd13);
    idle();
    for (int n = 0; n < 20 && !bus_if.out_valid; n++) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(bus_if.in_ready),  64'd0);
      check("t4_stall_hold",  64'(bus_if.out_min),   64'd5);
    end
    check("t4_none_early", 64'(rq.size()), 64'd0);
    bus_if.out_ready = 1'b1;
    wait_result("t4_a", 32'd5, 8'd11, 1'b0, 8'd1);
    wait_result("t4_b", 32'd9, 8'd12, 1'b0, 8'd1);
    wait_result("t4_c", 32'd2, 8'd13, 1'b0, 8'd1);
    repeat (5) @(negedge clk);
    check("t4_no_dup",   64'(rq.size()),         64'd0);
    check("t4_drop_vld", 64'(bus_if.out_valid),  64'd0);

    send(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 32'd10, 32'd0, 8'd1);
    send(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd20, 32'd0, 8'd2);
    idle();
    rst = 1'b0;
    #1 check("t5_rst_valid", 64'(bus_if.out_valid), 64'd0);
    @(negedge clk);
    check("t5_rst_min", 64'(bus_if.out_min), 64'hFFFF_FFFF);
    rst = 1'b1;
    send(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 32'd42, 32'd0, 8'd7);
    idle();
    wait_result("t5_after_rst", 32'd42, 8'd7, 1'b0, 8'd1);

    send(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd100, 32'd0, 8'd1);
    send(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 32'd50,  32'd0, 8'd2);
    idle();
    wait_result("t6_implicit", 32'd50, 8'd2, 1'b0, 8'd2);

    send(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 32'd3, 32'd0, 8'd1);
    send(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 32'd8, 32'd0, 8'd2);
    idle();
    wait_result("t7_abandon", 32'd8, 8'd2, 1'b0, 8'd1);

    repeat (5) @(negedge clk);
    check("end_no_extra", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
